mmio_gpio_bridge: RTL and testbench

//  CPU-side bridge that feeds the memory-mapped GPIO register block. Accepts

---
 rtl/mmio_gpio_bridge_pkg.sv | 19 +
 rtl/mmio_addr_decode.sv | 17 +
 rtl/mmio_gpio_bridge.sv | 173 +++++++++++++++++
 tb/tb_mmio_gpio_bridge.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_gpio_bridge_pkg.sv
// rtl/mmio_gpio_bridge_pkg.sv - shared widths, address-map defaults and FSM states for the MMIO bridges
package mmio_gpio_bridge_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 3;

    localparam logic [ADDR_W-1:0] GPIO_BASE_DEF  = 32'h0000_0030;
    localparam logic [ADDR_W-1:0] GPIO_MASK_DEF  = 32'hFFFF_FFFC;
    localparam logic [ADDR_W-1:0] ERR_STATUS_OFS = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/mmio_addr_decode.sv
// rtl/mmio_addr_decode.sv - combinational window hit and error-status register decode
module mmio_addr_decode
    import mmio_gpio_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE       = GPIO_BASE_DEF,
    parameter logic [ADDR_W-1:0] MASK       = GPIO_MASK_DEF,
    parameter logic [ADDR_W-1:0] STATUS_OFS = ERR_STATUS_OFS
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic              status_hit
);

    assign hit        = ((addr & MASK) == BASE);
    assign status_hit = ((addr & MASK) == (BASE + STATUS_OFS));

endmodule

// File: rtl/mmio_gpio_bridge.sv
// rtl/mmio_gpio_bridge.sv - CPU valid/ready to GPIO register port bridge with timed reads
// Optional error response and sticky status register: MMIO_ERR_RESP_EN
module mmio_gpio_bridge
    import mmio_gpio_bridge_pkg::*;
#(
    parameter logic [ADDR_W-1:0] GPIO_BASE = GPIO_BASE_DEF,
    parameter logic [ADDR_W-1:0] GPIO_MASK = GPIO_MASK_DEF,
    parameter int                RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [3:0]        cpu_wstrb,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    output logic [ADDR_W-1:0] gpio_addr,
    output logic [DATA_W-1:0] gpio_wdata,
    output logic              gpio_we,
    input  logic [DATA_W-1:0] gpio_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : '0;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_rd_q, is_rd_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic              cpu_err_q, cpu_err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [ADDR_W-1:0] gpio_addr_q, gpio_addr_d;
    logic [DATA_W-1:0] gpio_wdata_q, gpio_wdata_d;
    logic              gpio_we_q, gpio_we_d;

    logic              hit, status_hit, is_write;
    logic [DATA_W-1:0] miss_rdata;
    logic              miss_err;

    assign is_write = |cpu_wstrb;

    mmio_addr_decode #(
        .BASE       (GPIO_BASE),
        .MASK       (GPIO_MASK),
        .STATUS_OFS (ERR_STATUS_OFS)
    ) u_decode (
        .addr       (cpu_addr),
        .hit        (hit),
        .status_hit (status_hit)
    );

`ifdef MMIO_ERR_RESP_EN
    logic err_seen_q, err_seen_d;

    // The status word is answered locally, so it is neither a miss nor a GPIO access.
    assign miss_rdata = status_hit ? {{(DATA_W-1){1'b0}}, err_seen_q} : '0;
    assign miss_err   = !status_hit;

    always_comb begin
        err_seen_d = err_seen_q;
        if (state_q == ST_IDLE && cpu_valid && !hit && !status_hit) begin
            err_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seen_q <= 1'b0;
        end else begin
            err_seen_q <= err_seen_d;
        end
    end
`else
    logic unused_status_hit;

    assign unused_status_hit = status_hit;
    assign miss_rdata        = '0;
    assign miss_err          = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_rd_d      = is_rd_q;
        cpu_ready_d  = 1'b0;
        cpu_err_d    = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        gpio_addr_d  = gpio_addr_q;
        gpio_wdata_d = gpio_wdata_q;
        gpio_we_d    = 1'b0;
        // Response flops are loaded on the edge that enters RESP so they line up with state.
        unique case (state_q)
            ST_IDLE: begin
                if (cpu_valid) begin
                    if (hit) begin
                        state_d      = ST_ACCESS;
                        gpio_addr_d  = cpu_addr;
                        gpio_wdata_d = cpu_wdata;
                        gpio_we_d    = is_write;
                        is_rd_d      = !is_write;
                    end else begin
                        state_d     = ST_RESP;
                        cpu_ready_d = 1'b1;
                        cpu_rdata_d = miss_rdata;
                        cpu_err_d   = miss_err;
                    end
                end
            end
            ST_ACCESS: begin
                if (!is_rd_q) begin
                    state_d     = ST_RESP;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = '0;
                end else if (RD_LAT == 0) begin
                    state_d     = ST_RESP;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = gpio_rdata;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    cpu_ready_d = 1'b1;
                    cpu_rdata_d = gpio_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            is_rd_q      <= 1'b0;
            cpu_ready_q  <= 1'b0;
            cpu_err_q    <= 1'b0;
            cpu_rdata_q  <= '0;
            gpio_addr_q  <= '0;
            gpio_wdata_q <= '0;
            gpio_we_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_rd_q      <= is_rd_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_err_q    <= cpu_err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            gpio_addr_q  <= gpio_addr_d;
            gpio_wdata_q <= gpio_wdata_d;
            gpio_we_q    <= gpio_we_d;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_err    = cpu_err_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign gpio_addr  = gpio_addr_q;
    assign gpio_wdata = gpio_wdata_q;
    assign gpio_we    = gpio_we_q;

endmodule

// File: tb/tb_mmio_gpio_bridge.sv
// tb/tb_mmio_gpio_bridge.sv - scoreboard bench for mmio_gpio_bridge at RD_LAT 1, 0 and 3
module tb_mmio_gpio_bridge;

    localparam int ND = 3;
    localparam int LAT_OF [ND] = '{1, 0, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_valid [ND];
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready [ND];
    logic [31:0] cpu_rdata [ND];
    logic        cpu_err [ND];
    logic [31:0] gpio_addr [ND];
    logic [31:0] gpio_wdata [ND];
    logic        gpio_we [ND];
    logic [31:0] gpio_rdata [ND];

    always #5 clk = ~clk;

    mmio_gpio_bridge #(.RD_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid[0]), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready[0]),
        .cpu_rdata(cpu_rdata[0]), .cpu_err(cpu_err[0]), .gpio_addr(gpio_addr[0]),
        .gpio_wdata(gpio_wdata[0]), .gpio_we(gpio_we[0]), .gpio_rdata(gpio_rdata[0])
    );

    mmio_gpio_bridge #(.RD_LAT(0)) u_lat0 (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid[1]), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready[1]),
        .cpu_rdata(cpu_rdata[1]), .cpu_err(cpu_err[1]), .gpio_addr(gpio_addr[1]),
        .gpio_wdata(gpio_wdata[1]), .gpio_we(gpio_we[1]), .gpio_rdata(gpio_rdata[1])
    );

    mmio_gpio_bridge #(.RD_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid[2]), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready[2]),
        .cpu_rdata(cpu_rdata[2]), .cpu_err(cpu_err[2]), .gpio_addr(gpio_addr[2]),
        .gpio_wdata(gpio_wdata[2]), .gpio_we(gpio_we[2]), .gpio_rdata(gpio_rdata[2])
    );

    int          cyc = 0;
    logic [31:0] gpio_reg = 32'h0;
    int          we_cnt = 0;
    int          last_we_cyc = -1;

    function automatic logic [31:0] pat(input int n);
        logic [31:0] v;
        v = n;
        return 32'hC0DE_0000 | (v & 32'h0000_FFFF);
    endfunction

    // GPIO block model for the RD_LAT=1 instance; the sweep instances see a per-cycle pattern.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gpio_we[0]) begin
            we_cnt      <= we_cnt + 1;
            last_we_cyc <= cyc + 1;
            if (gpio_addr[0] == 32'h30) gpio_reg <= gpio_wdata[0];
        end
    end

    assign gpio_rdata[0] = (gpio_addr[0] == 32'h30) ? gpio_reg : 32'h0;
    assign gpio_rdata[1] = pat(cyc);
    assign gpio_rdata[2] = pat(cyc);

    typedef struct {
        int          dut;
        logic [31:0] rdata;
        logic        err;
        int          edge_at;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   resp_cnt = 0;

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < ND; d++) begin
            if (rst_n && cpu_ready[d]) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_ready dut=%0d cyc=%0d got=1 exp=0", d, cyc);
                end else begin
                    e = sb.pop_front();
                    resp_cnt++;
                    if (e.dut != d) begin
                        failures++;
                        $display("FAIL resp_dut got=%0d exp=%0d", d, e.dut);
                    end
                    checks++;
                    if (cpu_rdata[d] !== e.rdata) begin
                        failures++;
                        $display("FAIL rdata dut=%0d got=%h exp=%h", d, cpu_rdata[d], e.rdata);
                    end
                    checks++;
                    if (cpu_err[d] !== e.err) begin
                        failures++;
                        $display("FAIL err dut=%0d got=%b exp=%b", d, cpu_err[d], e.err);
                    end
                    checks++;
                    if (cyc + 1 != e.edge_at) begin
                        failures++;
                        $display("FAIL ready_edge dut=%0d got=%0d exp=%0d", d, cyc + 1, e.edge_at);
                    end
                end
            end
        end
    end

    task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input logic [31:0] exp_rd, input logic exp_err,
                          input int lat, input int exp_we, input bit use_pat, output int t);
        int   start_resp;
        int   start_we;
        exp_t e;
        bit   done;
        @(negedge clk);
        cpu_addr     = a;
        cpu_wdata    = wd;
        cpu_wstrb    = ws;
        cpu_valid[d] = 1'b1;
        start_resp   = resp_cnt;
        start_we     = we_cnt;
        @(posedge clk);
        #1;
        t         = cyc;
        e.dut     = d;
        e.rdata   = use_pat ? pat(t + LAT_OF[d]) : exp_rd;
        e.err     = exp_err;
        e.edge_at = t + lat;
        sb.push_back(e);
        done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            @(negedge clk);
            #1;
            if (resp_cnt != start_resp) done = 1'b1;
        end
        cpu_valid[d] = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL timeout dut=%0d addr=%h got=no_ready exp=ready", d, a);
            sb.delete();
        end
        if (d == 0) begin
            checks++;
            if (we_cnt - start_we != exp_we) begin
                failures++;
                $display("FAIL we_count addr=%h got=%0d exp=%0d", a, we_cnt - start_we, exp_we);
            end
            if (exp_we == 1) begin
                checks++;
                if (last_we_cyc != t + 1) begin
                    failures++;
                    $display("FAIL we_edge got=%0d exp=%0d", last_we_cyc, t + 1);
                end
            end
        end
    endtask

    task automatic test_reset();
        int r0;
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (cpu_ready[d] !== 1'b0 || cpu_err[d] !== 1'b0 || gpio_we[d] !== 1'b0 ||
                cpu_rdata[d] !== 32'h0 || gpio_addr[d] !== 32'h0 || gpio_wdata[d] !== 32'h0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d got=%b%b%b/%h/%h/%h exp=000/0/0/0", d,
                         cpu_ready[d], cpu_err[d], gpio_we[d], cpu_rdata[d], gpio_addr[d], gpio_wdata[d]);
            end
        end
        @(negedge clk);
        rst_n        = 1'b1;
        @(negedge clk);
        cpu_addr     = 32'h30;
        cpu_wdata    = 32'h1234_5678;
        cpu_wstrb    = 4'hF;
        cpu_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (gpio_we[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_pre_we got=%b exp=1", gpio_we[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (gpio_we[0] !== 1'b0 || gpio_addr[0] !== 32'h0 || gpio_wdata[0] !== 32'h0 ||
            cpu_ready[0] !== 1'b0 || cpu_rdata[0] !== 32'h0 || cpu_err[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_access got=we%b addr%h wdata%h exp=all_zero",
                     gpio_we[0], gpio_addr[0], gpio_wdata[0]);
        end
        cpu_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r0 = resp_cnt;
        repeat (3) @(negedge clk);
        checks++;
        if (we_cnt != 0 || gpio_reg !== 32'h0 || resp_cnt != r0) begin
            failures++;
            $display("FAIL reset_no_partial got=we%0d reg%h exp=we0 reg0", we_cnt, gpio_reg);
        end
    endtask

    task automatic test_write_hit();
        int t;
        do_req(0, 32'h30, 32'hAA, 4'hF, 32'h0, 1'b0, 2, 1, 1'b0, t);
        checks++;
        if (gpio_reg !== 32'hAA || gpio_wdata[0] !== 32'hAA) begin
            failures++;
            $display("FAIL write_hit_gpio got=%h/%h exp=000000aa", gpio_reg, gpio_wdata[0]);
        end
    endtask

    task automatic test_read_hit();
        int t;
        do_req(0, 32'h30, 32'h0, 4'h0, 32'h0000_00AA, 1'b0, 3, 0, 1'b0, t);
    endtask

    task automatic test_miss();
        int t;
`ifdef MMIO_ERR_RESP_EN
        do_req(0, 32'h100, 32'h55, 4'hF, 32'h0, 1'b1, 1, 0, 1'b0, t);
        do_req(0, 32'h34, 32'h0, 4'h0, 32'h1, 1'b0, 1, 0, 1'b0, t);
`else
        do_req(0, 32'h100, 32'h55, 4'hF, 32'h0, 1'b0, 1, 0, 1'b0, t);
        do_req(0, 32'h34, 32'h0, 4'h0, 32'h0, 1'b0, 1, 0, 1'b0, t);
`endif
        checks++;
        if (gpio_reg !== 32'hAA) begin
            failures++;
            $display("FAIL miss_gpio_untouched got=%h exp=000000aa", gpio_reg);
        end
    endtask

    task automatic test_back_to_back();
        int t1;
        int t2;
        do_req(0, 32'h30, 32'h0F, 4'hF, 32'h0, 1'b0, 2, 1, 1'b0, t1);
        do_req(0, 32'h30, 32'h0, 4'h0, 32'h0F, 1'b0, 3, 0, 1'b0, t2);
        checks++;
        if (t2 != t1 + 3) begin
            failures++;
            $display("FAIL b2b_accept_edge got=%0d exp=%0d", t2, t1 + 3);
        end
    endtask

    task automatic test_rd_lat_sweep();
        int t;
        do_req(1, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 2, 0, 1'b1, t);
        do_req(2, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 5, 0, 1'b1, t);
        do_req(1, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 2, 0, 1'b1, t);
        do_req(2, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 5, 0, 1'b1, t);
    endtask

    initial begin
        rst_n     = 1'b0;
        cpu_addr  = 32'h0;
        cpu_wdata = 32'h0;
        cpu_wstrb = 4'h0;
        for (int d = 0; d < ND; d++) cpu_valid[d] = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_write_hit();
        test_read_hit();
        test_miss();
        test_back_to_back();
        test_rd_lat_sweep();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL leftover_expect got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
